// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and its surroundings:
// sweep control, gate-under-test drive/observe, and result reporting.
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;

    modport master (
        output start, abort, dut_out,
        input  in1, in2, in3, busy, done, table_out, match
    );

    modport slave (
        input  start, abort, dut_out,
        output in1, in2, in3, busy, done, table_out, match
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives the eight input vectors of a 3-input gate in order, samples its output
// after a settle time, and checks the assembled truth-table code.
module truth_table_sweeper #(
    parameter int         SETTLE   = 2,
    parameter logic [7:0] EXPECTED = 8'h59
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_r, next_state_s;
    logic [2:0] row_r, next_row_s;
    logic [3:0] wcnt_r, next_wcnt_s;
    logic [7:0] cap_r, next_cap_s;
    logic [7:0] table_r, next_table_s;
    logic       match_r, next_match_s;
    logic [2:0] drive_r, next_drive_s;
    logic       busy_r, done_r;
    logic [7:0] captured_s;

    // Row 000 lands in bit 7, row 111 in bit 0.
    function automatic logic [7:0] insert_bit(input logic [7:0] v,
                                              input logic [2:0] row,
                                              input logic       b);
        logic [7:0] r;
        r = v;
        r[3'd7 - row] = b;
        return r;
    endfunction

    // Next-state and next-register computation for the sweep sequencer.
    always_comb begin
        next_state_s = state_r;
        next_row_s   = row_r;
        next_wcnt_s  = wcnt_r;
        next_cap_s   = cap_r;
        next_table_s = table_r;
        next_match_s = match_r;
        captured_s   = insert_bit(cap_r, row_r, bus.dut_out);
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    next_state_s = ST_WAIT;
                    next_row_s   = 3'd0;
                    next_wcnt_s  = 4'd0;
                    next_cap_s   = 8'h00;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                    next_cap_s   = 8'h00;
                end else begin
                    next_wcnt_s = wcnt_r + 4'd1;
                    if (wcnt_r == SETTLE_LAST) begin
                        next_state_s = ST_SAMPLE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
            end
            ST_SAMPLE: begin
                // Abort beats the final sample, so results stay untouched.
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                    next_cap_s   = 8'h00;
                end else begin
                    next_cap_s = captured_s;
                    if (row_r == 3'd7) begin
                        next_table_s = captured_s;
                        next_match_s = (captured_s == EXPECTED);
                        next_state_s = ST_DONE;
                    end else begin
                        next_row_s   = row_r + 3'd1;
                        next_wcnt_s  = 4'd0;
                        next_state_s = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Gate drive follows the upcoming state so the outputs can be registered.
    always_comb begin
        if ((next_state_s == ST_WAIT) || (next_state_s == ST_SAMPLE)) begin
            next_drive_s = next_row_s;
        end else begin
            next_drive_s = 3'b000;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            row_r   <= 3'd0;
            wcnt_r  <= 4'd0;
            cap_r   <= 8'h00;
            table_r <= 8'h00;
            match_r <= 1'b0;
            drive_r <= 3'b000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            row_r   <= next_row_s;
            wcnt_r  <= next_wcnt_s;
            cap_r   <= next_cap_s;
            table_r <= next_table_s;
            match_r <= next_match_s;
            drive_r <= next_drive_s;
            busy_r  <= (next_state_s == ST_WAIT) || (next_state_s == ST_SAMPLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    assign bus.in1       = drive_r[2];
    assign bus.in2       = drive_r[1];
    assign bus.in3       = drive_r[0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.table_out = table_r;
    assign bus.match     = match_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of gate models with known
// truth-table codes, plus abort, start-hold and async-reset sequences.
module tb_truth_table_sweeper;

    logic clk;
    logic rst;
    logic [2:0] mode;
    int tests;
    int fails;

    truth_table_sweeper_if bus ();

    truth_table_sweeper #(.SETTLE(2), .EXPECTED(8'h59)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate models selected by mode.
    function automatic logic gate(input logic [2:0] m, input logic [2:0] idx);
        logic [7:0] t59;
        t59 = 8'h59;
        case (m)
            3'd0:    return t59[3'd7 - idx];
            3'd1:    return &idx;
            3'd2:    return 1'b1;
            3'd3:    return 1'b0;
            3'd4:    return |idx;
            3'd5:    return ^idx;
            3'd6:    return idx[2];
            default: return 1'b0;
        endcase
    endfunction

    assign bus.dut_out = gate(mode, {bus.in1, bus.in2, bus.in3});

    typedef struct {
        logic [2:0] mode;
        logic [7:0] exp_table;
        logic       exp_match;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start and watch up to 40 cycles; cycle 1 is the one after the accepting edge.
    task automatic run_sweep(output int done_cyc, output int ndone, output int vec_err);
        done_cyc = 0;
        ndone    = 0;
        vec_err  = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                ndone++;
                done_cyc = c;
            end
            if (c <= 24) begin
                if (bus.busy !== 1'b1 || {bus.in1, bus.in2, bus.in3} !== 3'((c - 1) / 3))
                    vec_err++;
            end else begin
                if (bus.busy !== 1'b0 || {bus.in1, bus.in2, bus.in3} !== 3'b000)
                    vec_err++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, nd, ve;
        tests = 0;
        fails = 0;
        mode = 3'd0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst = 1'b1;

        vecs[0] = '{3'd0, 8'h59, 1'b1};
        vecs[1] = '{3'd1, 8'h01, 1'b0};
        vecs[2] = '{3'd2, 8'hFF, 1'b0};
        vecs[3] = '{3'd3, 8'h00, 1'b0};
        vecs[4] = '{3'd4, 8'h7F, 1'b0};
        vecs[5] = '{3'd5, 8'h69, 1'b0};
        vecs[6] = '{3'd6, 8'h0F, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy",  32'(bus.busy), 32'd0);
        chk("reset_done",  32'(bus.done), 32'd0);
        chk("reset_in",    32'({bus.in1, bus.in2, bus.in3}), 32'd0);
        chk("reset_table", 32'(bus.table_out), 32'h00);
        chk("reset_match", 32'(bus.match), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            run_sweep(dc, nd, ve);
            chk($sformatf("sweep%0d_done_cycle", i), 32'(dc), 32'd25);
            chk($sformatf("sweep%0d_done_count", i), 32'(nd), 32'd1);
            chk($sformatf("sweep%0d_vectors", i),    32'(ve), 32'd0);
            chk($sformatf("sweep%0d_table", i),      32'(bus.table_out), 32'(vecs[i].exp_table));
            chk($sformatf("sweep%0d_match", i),      32'(bus.match), 32'(vecs[i].exp_match));
        end

        // Re-establish a known 0x59 result before the abort sequences.
        mode = 3'd0;
        run_sweep(dc, nd, ve);
        chk("pre_abort_table", 32'(bus.table_out), 32'h59);

        // Abort during row 5 WAIT (cycle 16) with a constant-1 gate.
        mode = 3'd2;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_in_row5", 32'({bus.in1, bus.in2, bus.in3}), 32'd5);
        bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_in",   32'({bus.in1, bus.in2, bus.in3}), 32'd0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        chk("abort_table",   32'(bus.table_out), 32'h59);
        chk("abort_match",   32'(bus.match), 32'd1);

        // Abort coinciding with the row-7 SAMPLE edge (cycle 24).
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (23) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk) bus.abort = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("race_no_done", 32'(nd), 32'd0);
        chk("race_table",   32'(bus.table_out), 32'h59);

        // Start and abort together in IDLE: nothing happens.
        @(negedge clk) begin bus.start = 1'b1; bus.abort = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.abort = 1'b0; end
        chk("idle_abort_start", 32'(bus.busy), 32'd0);

        // Start held high: back-to-back sweeps with a single IDLE cycle between.
        mode = 3'd1;
        @(negedge clk) bus.start = 1'b1;
        nd = 0;
        dc = 0;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (nd == 1) chk("hold_done1_cycle", 32'(c), 32'd25);
                if (nd == 2) chk("hold_done2_cycle", 32'(c), 32'd51);
            end
            if (c == 26) chk("hold_idle_gap", 32'(bus.busy), 32'd0);
            if (c == 27) chk("hold_restart",  32'(bus.busy), 32'd1);
        end
        chk("hold_done_count", 32'(nd), 32'd2);
        chk("hold_table",      32'(bus.table_out), 32'h01);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);

        // Async reset mid-sweep, between edges.
        mode = 3'd0;
        run_sweep(dc, nd, ve);
        chk("prereset_table", 32'(bus.table_out), 32'h59);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_busy",  32'(bus.busy), 32'd0);
        chk("areset_in",    32'({bus.in1, bus.in2, bus.in3}), 32'd0);
        chk("areset_done",  32'(bus.done), 32'd0);
        chk("areset_table", 32'(bus.table_out), 32'h00);
        chk("areset_match", 32'(bus.match), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sweep(dc, nd, ve);
        chk("post_reset_done_cycle", 32'(dc), 32'd25);
        chk("post_reset_table",      32'(bus.table_out), 32'h59);
        chk("post_reset_match",      32'(bus.match), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer for a 3-input combinational logic gate such as the 0x59 function. On `start` it drives all eight input vectors 000..111 onto the gate, in order. It waits a programmable settle time per vector, samples the gate output and assembles the 8-bit truth-table code. When the sweep finishes it compares the code against an expected value and reports the result. It sits beside the gate under test and owns the gate inputs for the duration of a sweep.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling. Legal range 1..15.
- `EXPECTED`, default 8'h59: truth-table code the gate should produce.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a sweep; sampled only in IDLE.
- `abort`  input  1  cancel a running sweep.
- `dut_out`  input  1  output of the gate under test.
- `in1`, `in2`, `in3`  output  1 each  registered drive to the gate inputs; `in1` is the MSB of the row index.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `table_out`  output  8  last completed truth-table code.
- `match`  output  1  `table_out == EXPECTED`; valid from `done` onward.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE.
- Registers:
  - `row[2:0]`: current vector index.
  - `wcnt[3:0]`: settle counter.
  - `cap[7:0]`: capture shift register.
- Output drive: `{in1,in2,in3} = row` in WAIT and SAMPLE; 3'b000 otherwise.
- **IDLE:**
  - `busy=0`.
  - On an edge with `start=1` and `abort=0`: `row←0`, `wcnt←0`, `cap←0`, go to WAIT.
- **WAIT:**
  - `busy=1`.
  - Each edge: `wcnt←wcnt+1`.
  - When `wcnt==SETTLE-1` on the edge, go to SAMPLE.
- **SAMPLE:**
  - `busy=1`.
  - On the edge: `cap[7-row] ← dut_out`.
  - If `row==7`: `table_out ← {cap with that bit}`, `match ←` comparison of that new value with `EXPECTED`, go to DONE.
  - Otherwise: `row←row+1`, `wcnt←0`, go to WAIT.
- **DONE:**
  - `busy=0`, `done=1` for exactly one cycle.
  - Unconditionally go to IDLE. `start` seen in this cycle is ignored.
- Code bit mapping: bit 7 = output for row 000, bit 0 = output for row 111. For the 0x59 gate this yields 8'h59.
- `abort=1` on any edge while in WAIT or SAMPLE:
  - Go to IDLE; no `done` pulse.
  - `table_out` and `match` are unchanged.
  - `cap` is discarded.
- Simultaneous `abort` and the final SAMPLE edge: abort wins; `table_out` is not updated.
- `start` while busy or in DONE: ignored; it is not queued.
- `abort` in IDLE: no effect; `start` on the same edge is ignored.

## Timing
- Reset values, applied immediately on `rst` rise and held while `rst=1`:
  - State IDLE.
  - `in1=in2=in3=0`, `busy=0`, `done=0`.
  - `table_out=8'h00`, `match=0`.
  - `row`, `wcnt`, `cap` all 0.
- Reset mid-sweep behaves the same as reset at any other time; the sweep is lost.
- Per row: SETTLE cycles in WAIT, then 1 cycle in SAMPLE, so `dut_out` is sampled after the vector has been stable for SETTLE+1 cycles.
- With `start` accepted at edge E0:
  - `busy` is high for cycles 1..8·(SETTLE+1).
  - `done` is high in cycle 8·(SETTLE+1)+1.
  - `table_out` and `match` are already updated in the `done` cycle.
- With the default SETTLE=2: 24 busy cycles, `done` in cycle 25.
- Back-to-back sweeps: the earliest next accepted `start` is the edge ending the first IDLE cycle after DONE.
- Outputs `in1`..`in3`, `busy`, `done`, `table_out`, `match` are all registered; none is a combinational function of the inputs.

## Test plan
- **Nominal sweep:** behavioural 0x59 gate model, SETTLE=2, pulse `start`. Required:
  - Vectors appear in order 000..111, each held 3 cycles.
  - `done` in cycle 25.
  - `table_out=8'h59`, `match=1`.
- **Mismatch:** gate model replaced by 3-input AND, `EXPECTED=8'h59`. Required:
  - `table_out=8'h01`, `match=0`.
  - `done` pulses exactly once.
- **Abort:** after a completed 0x59 sweep, start a new sweep with a constant-1 gate and assert `abort` during row 5 WAIT. Required:
  - Return to IDLE next cycle with `in`=000.
  - No `done`.
  - `table_out` stays 8'h59.
- **Abort race:** `abort` coincides with the row-7 SAMPLE edge. Required:
  - No `done`.
  - `table_out` unchanged.
- **Start hygiene:** `start` held high continuously. Required:
  - Sweeps run back-to-back with exactly one IDLE cycle between DONE and the next WAIT.
  - Extra `start` pulses while busy do not restart or extend the sweep.
- **Async reset:** assert `rst` mid-sweep, between clock edges. Required:
  - All outputs go to reset values before the next edge.
  - After release, a new sweep completes normally with `table_out=8'h59`.
